branch_predictor: RTL and testbench

- Fetch-stage dynamic predictor; the upstream producer of the branch_predict bit consumed by the EX-stage branch/jump unit.
- Direct-mapped BTB; each entry holds a 2-bit saturating counter, looked up combinationally on the IF PC.
- Updated from EX with resolved outcome/target; keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_predictor.sv | 157 +++++++++++++++
 tb/tb_branch_predictor.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor: direct-mapped BTB with 2-bit counters,
// trained from EX, plus saturating branch/mispredict statistics.

module branch_predictor_entry #(
  parameter int TAG_BITS = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sel,
  input  logic                valid_set,
  input  logic                valid_clr,
  input  logic                tag_we,
  input  logic                target_we,
  input  logic                ctr_we,
  input  logic [TAG_BITS-1:0] wr_tag,
  input  logic [31:0]         wr_target,
  input  logic [1:0]          wr_ctr,
  input  logic                wr_is_jal,
  output logic                valid,
  output logic [TAG_BITS-1:0] tag,
  output logic [31:0]         target,
  output logic [1:0]          ctr,
  output logic                is_jal
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid  <= 1'b0;
      ctr    <= 2'b00;
      is_jal <= 1'b0;
    end else if (sel) begin
      if (valid_set)      valid <= 1'b1;
      else if (valid_clr) valid <= 1'b0;
      if (ctr_we) ctr    <= wr_ctr;
      if (tag_we) is_jal <= wr_is_jal;
    end
  end

  // Tag/target are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (sel && tag_we)    tag    <= wr_tag;
    if (sel && target_we) target <= wr_target;
  end

endmodule

module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          if_pc,
  output logic                 predict_taken,
  output logic [31:0]          predict_pc,
  input  logic                 ex_valid,
  input  logic [31:0]          ex_pc,
  input  logic                 ex_is_branch,
  input  logic                 ex_is_jump,
  input  logic                 ex_is_jumpr,
  input  logic                 ex_taken,
  input  logic [31:0]          ex_target,
  input  logic                 ex_flush,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int ENTRIES  = 1 << INDEX_BITS;
  localparam int TAG_BITS = 30 - INDEX_BITS;

  logic [ENTRIES-1:0]               valid_q;
  logic [ENTRIES-1:0]               is_jal_q;
  logic [ENTRIES-1:0][TAG_BITS-1:0] tag_q;
  logic [ENTRIES-1:0][31:0]         target_q;
  logic [ENTRIES-1:0][1:0]          ctr_q;

  logic [INDEX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_BITS-1:0]   if_tag, ex_tag;
  logic                  if_hit, ex_hit;

  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign if_tag = if_pc[31:INDEX_BITS+2];
  assign ex_idx = ex_pc[INDEX_BITS+1:2];
  assign ex_tag = ex_pc[31:INDEX_BITS+2];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  // Lookup reads registered state, so a same-cycle update is seen next cycle.
  assign if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign predict_taken = if_hit && (is_jal_q[if_idx] || ctr_q[if_idx][1]);
  assign predict_pc    = predict_taken ? target_q[if_idx] : if_pc + 32'd4;

  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  logic       do_branch, do_jump, do_jumpr;
  logic       wr_alloc, wr_train, wr_inval;
  logic       target_we, ctr_we;
  logic [1:0] cur_ctr, train_ctr, wr_ctr;

  always_comb begin
    do_branch = ex_valid & ex_is_branch;
    do_jump   = ex_valid & ~ex_is_branch & ex_is_jump;
    do_jumpr  = ex_valid & ~ex_is_branch & ~ex_is_jump & ex_is_jumpr;

    wr_alloc  = do_jump | (do_branch & ~ex_hit & ex_taken);
    wr_train  = do_branch & ex_hit;
    wr_inval  = do_jumpr & ex_hit;

    cur_ctr   = ctr_q[ex_idx];
    train_ctr = cur_ctr;
    if (ex_taken) begin
      if (cur_ctr != 2'b11) train_ctr = cur_ctr + 2'd1;
    end else begin
      if (cur_ctr != 2'b00) train_ctr = cur_ctr - 2'd1;
    end

    wr_ctr    = wr_alloc ? (do_jump ? 2'b11 : 2'b10) : train_ctr;
    ctr_we    = wr_alloc | wr_train;
    target_we = wr_alloc | (wr_train & ex_taken);
  end

  for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
    branch_predictor_entry #(.TAG_BITS(TAG_BITS)) u_entry (
      .clk       (clk),
      .reset     (reset),
      .sel       (ex_idx == INDEX_BITS'(i)),
      .valid_set (wr_alloc),
      .valid_clr (wr_inval),
      .tag_we    (wr_alloc),
      .target_we (target_we),
      .ctr_we    (ctr_we),
      .wr_tag    (ex_tag),
      .wr_target (ex_target),
      .wr_ctr    (wr_ctr),
      .wr_is_jal (do_jump),
      .valid     (valid_q[i]),
      .tag       (tag_q[i]),
      .target    (target_q[i]),
      .ctr       (ctr_q[i]),
      .is_jal    (is_jal_q[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (ex_valid && (ex_is_branch || ex_is_jump || ex_is_jumpr) && branch_count != '1)
        branch_count <= branch_count + CNT_WIDTH'(1);
      if (ex_flush && mispredict_count != '1)
        mispredict_count <= mispredict_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor (INDEX_BITS=6, CNT_WIDTH=4).

module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc;
  logic        predict_taken;
  logic [31:0] predict_pc;
  logic        ex_valid, ex_is_branch, ex_is_jump, ex_is_jumpr, ex_taken, ex_flush;
  logic [31:0] ex_pc, ex_target;
  logic [3:0]  branch_count, mispredict_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  branch_predictor #(.INDEX_BITS(6), .CNT_WIDTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .if_pc            (if_pc),
    .predict_taken    (predict_taken),
    .predict_pc       (predict_pc),
    .ex_valid         (ex_valid),
    .ex_pc            (ex_pc),
    .ex_is_branch     (ex_is_branch),
    .ex_is_jump       (ex_is_jump),
    .ex_is_jumpr      (ex_is_jumpr),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_flush         (ex_flush),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic look(input string tag, input logic [31:0] pc, input logic pt, input logic [31:0] ppc);
    if_pc = pc;
    #1;
    chk({tag, "_pt"}, {31'd0, predict_taken}, {31'd0, pt});
    chk({tag, "_ppc"}, predict_pc, ppc);
  endtask

  task automatic cnts(input string tag, input logic [3:0] bc, input logic [3:0] mc);
    chk({tag, "_bc"}, {28'd0, branch_count}, {28'd0, bc});
    chk({tag, "_mc"}, {28'd0, mispredict_count}, {28'd0, mc});
  endtask

  task automatic ex_clear();
    ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; ex_is_jumpr = 0; ex_taken = 0;
    ex_pc = 0; ex_target = 0;
  endtask

  task automatic ex_op(input logic [31:0] pc, input logic br, input logic j, input logic jr,
                       input logic tk, input logic [31:0] tgt);
    ex_valid = 1; ex_pc = pc; ex_is_branch = br; ex_is_jump = j; ex_is_jumpr = jr;
    ex_taken = tk; ex_target = tgt;
    @(posedge clk); #1;
    ex_clear();
  endtask

  initial begin
    reset = 1; ex_flush = 0; if_pc = 32'h100;
    ex_clear();
    look("rst", 32'h100, 0, 32'h104);
    cnts("rst", 4'd0, 4'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 0;

    // First allocation; same-cycle lookup must see old contents.
    ex_valid = 1; ex_pc = 32'h100; ex_is_branch = 1; ex_taken = 1; ex_target = 32'h80;
    look("same_cyc", 32'h100, 0, 32'h104);
    @(posedge clk); #1;
    ex_clear();
    look("alloc", 32'h100, 1, 32'h80);
    cnts("alloc", 4'd1, 4'd0);

    // Counter training: 10 -> 01 -> 00 -> 00(floor) -> 01 -> 10 -> 11 -> 11(ceil) -> 10
    ex_op(32'h100, 1, 0, 0, 0, 32'h0);
    look("nt1", 32'h100, 0, 32'h104);
    ex_op(32'h100, 1, 0, 0, 0, 32'h0);
    ex_op(32'h100, 1, 0, 0, 0, 32'h0);
    look("nt3", 32'h100, 0, 32'h104);
    ex_op(32'h100, 1, 0, 0, 1, 32'h80);
    look("t1", 32'h100, 0, 32'h104);
    ex_op(32'h100, 1, 0, 0, 1, 32'h80);
    look("t2", 32'h100, 1, 32'h80);
    ex_op(32'h100, 1, 0, 0, 1, 32'h80);
    ex_op(32'h100, 1, 0, 0, 1, 32'h80);
    ex_op(32'h100, 1, 0, 0, 0, 32'h0);
    look("ceil", 32'h100, 1, 32'h80);
    cnts("train", 4'd9, 4'd0);

    // Not-taken miss on an aliasing PC must not write.
    ex_op(32'h300, 1, 0, 0, 0, 32'h0);
    look("nt_miss", 32'h100, 1, 32'h80);

    // JAL aliasing index 0 replaces the 0x100 entry.
    ex_op(32'h200, 0, 1, 0, 1, 32'h1000);
    look("alias_old", 32'h100, 0, 32'h104);
    look("jal", 32'h200, 1, 32'h1000);

    ex_op(32'h400, 0, 0, 1, 1, 32'h4444);
    look("jalr_miss", 32'h200, 1, 32'h1000);
    ex_op(32'h200, 0, 0, 1, 1, 32'h4444);
    look("jalr_inv", 32'h200, 0, 32'h204);
    cnts("jalr", 4'd13, 4'd0);

    // Branch outranks jump: a not-taken miss branch writes nothing.
    ex_op(32'h500, 1, 1, 0, 0, 32'h5555);
    look("prio", 32'h500, 0, 32'h504);

    // Invalid EX slot is ignored.
    ex_pc = 32'h600; ex_is_branch = 1; ex_taken = 1; ex_target = 32'h60;
    @(posedge clk); #1;
    ex_clear();
    look("ex_inv", 32'h600, 0, 32'h604);
    cnts("ex_inv", 4'd14, 4'd0);

    ex_op(32'h700, 0, 1, 0, 1, 32'h40);
    ex_op(32'h800, 0, 0, 1, 1, 32'h0);
    look("jal2", 32'h700, 1, 32'h40);
    cnts("bc_sat", 4'd15, 4'd0);

    look("wrap", 32'hFFFF_FFFC, 0, 32'h0);

    // Mispredict counter saturation, independent of ex_valid.
    ex_flush = 1;
    for (int i = 0; i < 10; i++) @(posedge clk);
    #1;
    cnts("mc10", 4'd15, 4'd10);
    for (int i = 0; i < 10; i++) @(posedge clk);
    #1;
    cnts("mc_sat", 4'd15, 4'd15);

    // Asynchronous reset mid-cycle.
    #2;
    reset = 1;
    ex_flush = 0;
    #1;
    cnts("arst", 4'd0, 4'd0);
    look("arst", 32'h700, 0, 32'h704);

    // Update in flight during reset is dropped.
    ex_valid = 1; ex_pc = 32'h900; ex_is_branch = 1; ex_taken = 1; ex_target = 32'h90;
    @(posedge clk); #1;
    ex_clear();
    reset = 0;
    look("drop", 32'h900, 0, 32'h904);
    cnts("drop", 4'd0, 4'd0);

    // Both counters step together.
    ex_flush = 1;
    ex_op(32'h100, 1, 0, 0, 1, 32'h80);
    ex_flush = 0;
    cnts("both", 4'd1, 4'd1);
    look("realloc", 32'h100, 1, 32'h80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
